// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for data_mem_responder: FSM state encoding, default wait
// states and the address-error helper used when DATA_MEM_RESP_ERR_EN is defined.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_t;

  localparam int DMR_DEFAULT_WAIT_CYCLES = 2;

  // Misaligned byte address, or any bit set above the word-index field.
  function automatic logic dmr_addr_err(input logic [31:0] addr, input int addr_width);
    dmr_addr_err = (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_sram.sv
// Synchronous single-port word array for data_mem_responder. The contents are
// never reset; only the registered read port clears under reset.
module data_mem_responder_sram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // A store echoes its own data so the response carries what was written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: IDLE -> BUSY (WAIT_CYCLES) -> DONE, one-cycle
// response, stall toward the pipeline. Define DATA_MEM_RESP_ERR_EN to add resp_err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = DMR_DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
`ifdef DATA_MEM_RESP_ERR_EN
  output logic                  resp_err,
`endif
  output logic                  stall,
  output dmr_state_t            dbg_state
);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the response is a single-cycle resp_valid
  // pulse with no back-pressure from the requester.

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmr_state_t            state;
  logic [CW-1:0]         cnt;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept;
  logic                  access;
  logic                  cur_write;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  assign accept = (state == DMR_IDLE) && req_valid;
  // The array is touched on exactly the edge that enters DONE.
  assign access = (accept && (WAIT_CYCLES == 0)) || ((state == DMR_BUSY) && (cnt == '0));

  // With zero wait states the access happens on the capture edge itself.
  assign cur_write = (state == DMR_IDLE) ? req_write : wr_q;
  assign cur_idx   = (state == DMR_IDLE) ? req_addr[ADDR_WIDTH+1:2] : idx_q;
  assign cur_wdata = (state == DMR_IDLE) ? req_wdata : wdata_q;

  assign req_ready = (state == DMR_IDLE);
  assign stall     = accept || (state == DMR_BUSY);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DMR_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= access;
      case (state)
        DMR_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            wdata_q <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= DMR_DONE;
            end else begin
              state <= DMR_BUSY;
              cnt   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        DMR_BUSY: begin
          if (cnt == '0) begin
            state <= DMR_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DMR_DONE: state <= DMR_IDLE;
        default:  state <= DMR_IDLE;
      endcase
    end
  end

`ifdef DATA_MEM_RESP_ERR_EN
  logic err_q;
  logic resp_err_q;

  assign cur_err    = (state == DMR_IDLE) ? dmr_addr_err(req_addr, ADDR_WIDTH) : err_q;
  assign resp_err   = resp_err_q;
  // An erroring load reports zero rather than whatever the wrapped index holds.
  assign resp_rdata = resp_err_q ? '0 : sram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= dmr_addr_err(req_addr, ADDR_WIDTH);
      end
      if (access) begin
        resp_err_q <= cur_err;
      end
    end
  end
`else
  logic unused_addr_bits;

  assign cur_err          = 1'b0;
  assign resp_rdata       = sram_rdata;
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`endif

  data_mem_responder_sram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .en   (access),
    .we   (cur_write && !cur_err),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .rdata(sram_rdata)
  );

endmodule
